// File: rtl/spi_flash_responder.sv
// SPI NOR flash stand-in: oversamples a mode-0 SPI bus on p_clk and serves
// READ / PAGE PROGRAM / WREN / WRDI / RDSR from an internal byte array.
//
// state   | meaning
// IDLE    | deselected, waiting for s_css fall
// CMD     | shifting in the opcode byte
// ADDR    | shifting in the 3-byte address
// RD_DATA | streaming array bytes out on s_miso
// WR_DATA | programming received bytes into the current page
// STATUS  | streaming the status register out
// IGNORE  | holding quiet until deselect
module spi_flash_responder #(
  parameter int ADDR_BITS = 10,
  parameter int PAGE_BITS = 8
) (
  input  logic p_clk,
  input  logic p_reset,
  input  logic s_clk,
  input  logic s_css,
  input  logic s_mosi,
  output logic s_miso,
  output logic busy,
  output logic cmd_err
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PMASK = ADDR_BITS'((1 << PAGE_BITS) - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE} state_t;

  state_t               state;
  logic [1:0]           sclk_sync, css_sync, mosi_sync;
  logic                 sclk_prev, css_prev;
  logic                 wel, is_prog;
  logic [2:0]           bit_cnt, out_cnt;
  logic [1:0]           byte_cnt;
  logic [6:0]           in_sr;
  logic [7:0]           out_sr;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           mem [DEPTH];

  logic                 css_l, sclk_rise, sclk_fall, css_rise, css_fall, byte_done;
  logic [7:0]           in_byte;
  logic [ADDR_BITS-1:0] addr_shift, addr_inc, page_inc;

  assign css_l      = css_sync[1];
  assign sclk_rise  = sclk_sync[1] & ~sclk_prev & ~css_l;
  assign sclk_fall  = ~sclk_sync[1] & sclk_prev & ~css_l;
  assign css_rise   = css_l & ~css_prev;
  assign css_fall   = ~css_l & css_prev;
  assign in_byte    = {in_sr, mosi_sync[1]};
  assign byte_done  = sclk_rise && (bit_cnt == 3'd7);
  assign addr_shift = ADDR_BITS'({addr, in_byte});
  assign addr_inc   = addr + ADDR_BITS'(1);
  assign page_inc   = (addr & ~PMASK) | (addr_inc & PMASK);

  // Synchronizers reset to "selected" so a reset mid-frame cannot fake a CS fall.
  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      sclk_sync <= '0;
      css_sync  <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      css_prev  <= 1'b0;
      state     <= IDLE;
      s_miso    <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
      wel       <= 1'b0;
      is_prog   <= 1'b0;
      bit_cnt   <= '0;
      out_cnt   <= '0;
      byte_cnt  <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      addr      <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else begin
      sclk_sync <= {sclk_sync[0], s_clk};
      css_sync  <= {css_sync[0], s_css};
      mosi_sync <= {mosi_sync[0], s_mosi};
      sclk_prev <= sclk_sync[1];
      css_prev  <= css_l;
      cmd_err   <= 1'b0;
      if (css_l) s_miso <= 1'b0;

      if (css_rise) begin
        if (state == WR_DATA) wel <= 1'b0;
        state   <= IDLE;
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else if (css_fall) begin
        state    <= CMD;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        out_cnt  <= '0;
        busy     <= 1'b1;
        s_miso   <= 1'b0;
      end else begin
        if (sclk_rise) begin
          in_sr   <= in_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end

        if (byte_done) begin
          case (state)
            CMD: begin
              byte_cnt <= '0;
              case (in_byte)
                8'h03: begin is_prog <= 1'b0; state <= ADDR; end
                8'h02: begin
                  is_prog <= 1'b1;
                  state   <= wel ? ADDR : IGNORE;
                end
                8'h06: begin wel <= 1'b1; state <= IGNORE; end
                8'h04: begin wel <= 1'b0; state <= IGNORE; end
                8'h05: begin
                  out_sr  <= {6'b0, wel, 1'b0};
                  out_cnt <= '0;
                  state   <= STATUS;
                end
                default: begin cmd_err <= 1'b1; state <= IGNORE; end
              endcase
            end
            ADDR: begin
              addr     <= addr_shift;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd2) begin
                if (is_prog) begin
                  state <= WR_DATA;
                end else begin
                  out_sr  <= mem[addr_shift];
                  out_cnt <= '0;
                  state   <= RD_DATA;
                end
              end
            end
            WR_DATA: begin
              mem[addr] <= mem[addr] & in_byte;
              addr      <= page_inc;
            end
            default: ;
          endcase
        end

        if (sclk_fall && (state == RD_DATA || state == STATUS)) begin
          s_miso  <= out_sr[7];
          out_cnt <= out_cnt + 3'd1;
          if (out_cnt == 3'd7) begin
            if (state == RD_DATA) begin
              out_sr <= mem[addr_inc];
              addr   <= addr_inc;
            end else begin
              out_sr <= {6'b0, wel, 1'b0};
            end
          end else begin
            out_sr <= {out_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a table of SPI transactions with
// expected read-back bytes, plus hand sequences for abort/reset/error cases.
module tb_spi_flash_responder;
  logic p_clk = 1'b0;
  logic p_reset = 1'b1;
  logic s_clk = 1'b0;
  logic s_css = 1'b1;
  logic s_mosi = 1'b0;
  logic s_miso, busy, cmd_err;

  int n_checks = 0;
  int n_pass = 0;
  int err_cycles = 0;

  spi_flash_responder #(.ADDR_BITS(10), .PAGE_BITS(8)) dut (
    .p_clk(p_clk), .p_reset(p_reset), .s_clk(s_clk), .s_css(s_css),
    .s_mosi(s_mosi), .s_miso(s_miso), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 p_clk = ~p_clk;

  always @(negedge p_clk) if (cmd_err === 1'b1) err_cycles++;

  typedef struct packed {
    logic        rst;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [1:0]  n;
    logic [15:0] d;
    logic [15:0] e;
    logic        chk;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic r, logic [7:0] c, logic [23:0] a, logic [1:0] n,
                              logic [15:0] d, logic [15:0] e, logic k);
    vec_t v;
    v.rst = r; v.cmd = c; v.addr = a; v.n = n; v.d = d; v.e = e; v.chk = k;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
  endtask

  task automatic do_reset();
    p_reset = 1'b1;
    #30;
    p_reset = 1'b0;
    #20;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      s_mosi = tx[i];
      #40;
      rx[i] = s_miso;
      s_clk = 1'b1;
      #40;
      s_clk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic spi_begin();
    s_css = 1'b0;
    #40;
  endtask

  task automatic spi_end();
    #40;
    s_css = 1'b1;
    #80;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] rx;
    if (v.rst) do_reset();
    spi_begin();
    check($sformatf("vec%0d_busy_sel", idx), {7'd0, busy}, 8'd1);
    spi_xfer(v.cmd, rx);
    if (v.cmd == 8'h02 || v.cmd == 8'h03)
      for (int i = 2; i >= 0; i--) spi_xfer(v.addr[i*8 +: 8], rx);
    for (int i = 0; i < int'(v.n); i++) begin
      spi_xfer(i == 0 ? v.d[15:8] : v.d[7:0], rx);
      if (v.chk) check($sformatf("vec%0d_byte%0d", idx, i), rx, i == 0 ? v.e[15:8] : v.e[7:0]);
    end
    spi_end();
    check($sformatf("vec%0d_busy_desel", idx), {7'd0, busy}, 8'd0);
    check($sformatf("vec%0d_miso_desel", idx), {7'd0, s_miso}, 8'd0);
  endtask

  initial begin
    logic [7:0] rx;
    int err_base;

    vecs[0]  = mk(0, 8'h03, 24'h000010, 2, 16'h0000, 16'hFFFF, 1);
    vecs[1]  = mk(0, 8'h06, 24'h0,      0, 16'h0000, 16'h0000, 0);
    vecs[2]  = mk(0, 8'h02, 24'h000020, 2, 16'hA53C, 16'h0000, 1);
    vecs[3]  = mk(0, 8'h03, 24'h000020, 2, 16'h0000, 16'hA53C, 1);
    vecs[4]  = mk(0, 8'h05, 24'h0,      1, 16'h0000, 16'h0000, 1);
    vecs[5]  = mk(0, 8'h02, 24'h000000, 1, 16'h0000, 16'h0000, 1);
    vecs[6]  = mk(0, 8'h03, 24'h000000, 1, 16'h0000, 16'hFF00, 1);
    vecs[7]  = mk(0, 8'h06, 24'h0,      0, 16'h0000, 16'h0000, 0);
    vecs[8]  = mk(0, 8'h02, 24'h000000, 1, 16'hF000, 16'h0000, 1);
    vecs[9]  = mk(0, 8'h06, 24'h0,      0, 16'h0000, 16'h0000, 0);
    vecs[10] = mk(0, 8'h05, 24'h0,      1, 16'h0000, 16'h0200, 1);
    vecs[11] = mk(0, 8'h02, 24'h000000, 1, 16'h0F00, 16'h0000, 1);
    vecs[12] = mk(0, 8'h03, 24'h000000, 2, 16'h0000, 16'h00FF, 1);
    vecs[13] = mk(0, 8'h06, 24'h0,      0, 16'h0000, 16'h0000, 0);
    vecs[14] = mk(0, 8'h04, 24'h0,      0, 16'h0000, 16'h0000, 0);
    vecs[15] = mk(0, 8'h05, 24'h0,      1, 16'h0000, 16'h0000, 1);
    vecs[16] = mk(1, 8'h06, 24'h0,      0, 16'h0000, 16'h0000, 0);
    vecs[17] = mk(0, 8'h02, 24'h0000FF, 2, 16'h1122, 16'h0000, 1);
    vecs[18] = mk(0, 8'h03, 24'h000000, 1, 16'h0000, 16'h2200, 1);
    vecs[19] = mk(0, 8'h03, 24'h0000FF, 2, 16'h0000, 16'h11FF, 1);
    vecs[20] = mk(0, 8'h03, 24'h0003FF, 2, 16'h0000, 16'hFF22, 1);
    vecs[21] = mk(0, 8'h03, 24'hFFFC00, 1, 16'h0000, 16'h2200, 1);
    vecs[22] = mk(0, 8'h06, 24'h0,      0, 16'h0000, 16'h0000, 0);
    vecs[23] = mk(0, 8'h02, 24'h000020, 1, 16'h5A00, 16'h0000, 1);

    #20;
    p_reset = 1'b0;
    #20;
    check("reset_miso", {7'd0, s_miso}, 8'd0);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_cmd_err", {7'd0, cmd_err}, 8'd0);

    err_base = err_cycles;
    for (int i = 0; i < 24; i++) run_vec(i, vecs[i]);
    check("no_cmd_err_in_table", 8'(err_cycles - err_base), 8'd0);

    // unrecognised opcode
    err_base = err_cycles;
    spi_begin();
    spi_xfer(8'h9F, rx);
    check("bad_op_miso_cmd", rx, 8'h00);
    spi_xfer(8'hFF, rx);
    check("bad_op_miso_ignore", rx, 8'h00);
    spi_end();
    check("bad_op_err_cycles", 8'(err_cycles - err_base), 8'd1);
    run_vec(100, mk(0, 8'h03, 24'h0000FF, 1, 16'h0000, 16'h1100, 1));

    // deselect after 12 address bits
    spi_begin();
    spi_xfer(8'h03, rx);
    spi_xfer(8'h00, rx);
    spi_bits(8'h00, 4, rx);
    spi_end();
    check("abort_addr_busy", {7'd0, busy}, 8'd0);
    check("abort_addr_miso", {7'd0, s_miso}, 8'd0);
    run_vec(101, mk(0, 8'h03, 24'h000020, 1, 16'h0000, 16'h5A00, 1));

    // partial trailing program byte is discarded, WEL cleared
    run_vec(102, mk(0, 8'h06, 24'h0, 0, 16'h0000, 16'h0000, 0));
    spi_begin();
    spi_xfer(8'h02, rx);
    spi_xfer(8'h00, rx);
    spi_xfer(8'h00, rx);
    spi_xfer(8'h40, rx);
    spi_xfer(8'h00, rx);
    spi_bits(8'h00, 4, rx);
    spi_end();
    run_vec(103, mk(0, 8'h03, 24'h000040, 2, 16'h0000, 16'h00FF, 1));
    run_vec(104, mk(0, 8'h05, 24'h0, 1, 16'h0000, 16'h0000, 1));

    // reset in the middle of a read
    spi_begin();
    spi_xfer(8'h03, rx);
    spi_xfer(8'h00, rx);
    spi_xfer(8'h00, rx);
    spi_xfer(8'h20, rx);
    spi_xfer(8'h00, rx);
    check("rst_mid_first_byte", rx, 8'h5A);
    do_reset();
    check("rst_mid_miso", {7'd0, s_miso}, 8'd0);
    check("rst_mid_busy", {7'd0, busy}, 8'd0);
    spi_xfer(8'hFF, rx);
    check("rst_mid_ignored", rx, 8'h00);
    spi_end();
    run_vec(105, mk(0, 8'h03, 24'h000020, 1, 16'h0000, 16'hFF00, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
